// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exec_pkg
// Brief    : Shared types for the execute stage: ALU operation codes, MDU
//            FSM states and the MDU operation classifier.
// Revision : 1.0 - initial release
// ============================================================================
package exec_pkg;

    // Operation codes carried on ALU_control_E
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_MUL   = 4'd10,
        ALU_MULHU = 4'd11,
        ALU_DIVU  = 4'd12,
        ALU_REMU  = 4'd13
    } alu_op_e;

    // Iterative multiply/divide sequencer states
    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    // True for the multi-cycle operations handled by the MDU
    function automatic logic is_mdu(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU) ||
               (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage : exec_pkg
`default_nettype wire

// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iterative
// Brief    : Unsigned shift-add multiplier / restoring divider, one bit per
//            cycle. IDLE -> RUN (XLEN cycles) -> DONE -> IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iterative
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_opa,
    input  logic [XLEN-1:0] i_opb,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    mdu_state_e       r_state_q, w_state_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    // acc: high product half (MUL) or partial remainder (DIV)
    logic [XLEN-1:0]  r_acc_q,   w_acc_d;
    // lo: multiplier shifting out / low product half, or dividend shifting
    // out / quotient shifting in
    logic [XLEN-1:0]  r_lo_q,    w_lo_d;
    logic [XLEN-1:0]  r_opb_q,   w_opb_d;
    logic [3:0]       r_op_q,    w_op_d;

    logic             w_is_mul;
    logic [XLEN:0]    w_mul_sum;
    logic [XLEN:0]    w_div_shift;
    logic [XLEN:0]    w_div_trial;

    assign w_is_mul = (r_op_q == ALU_MUL) || (r_op_q == ALU_MULHU);

    // Multiply step: conditionally add multiplicand to the high half; the
    // carry becomes the new MSB after the right shift.
    assign w_mul_sum = {1'b0, r_acc_q} + (r_lo_q[0] ? {1'b0, r_opb_q} : '0);

    // Divide step: shift the next dividend bit into the remainder and try
    // subtracting the divisor; a set MSB of the trial means it went negative.
    // A zero divisor always succeeds, giving all-ones quotient and the
    // dividend as remainder with no special casing.
    assign w_div_shift = {r_acc_q, r_lo_q[XLEN-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opb_q};

    // Sequencer state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= MDU_IDLE;
            r_cnt_q   <= '0;
            r_acc_q   <= '0;
            r_lo_q    <= '0;
            r_opb_q   <= '0;
            r_op_q    <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_acc_q   <= w_acc_d;
            r_lo_q    <= w_lo_d;
            r_opb_q   <= w_opb_d;
            r_op_q    <= w_op_d;
        end
    end

    // Next-state, iteration datapath and busy/done outputs
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_acc_d   = r_acc_q;
        w_lo_d    = r_lo_q;
        w_opb_d   = r_opb_q;
        w_op_d    = r_op_q;
        o_busy    = 1'b0;
        o_done    = 1'b0;

        if (i_flush) begin
            w_state_d = MDU_IDLE;
            w_cnt_d   = '0;
        end else begin
            case (r_state_q)
                MDU_IDLE: begin
                    if (i_start) begin
                        o_busy    = 1'b1;
                        w_state_d = MDU_RUN;
                        w_cnt_d   = CNT_W'(XLEN);
                        w_acc_d   = '0;
                        w_lo_d    = i_opa;
                        w_opb_d   = i_opb;
                        w_op_d    = i_op;
                    end
                end
                MDU_RUN: begin
                    o_busy  = 1'b1;
                    w_cnt_d = r_cnt_q - CNT_W'(1);
                    if (w_is_mul) begin
                        w_acc_d = w_mul_sum[XLEN:1];
                        w_lo_d  = {w_mul_sum[0], r_lo_q[XLEN-1:1]};
                    end else if (!w_div_trial[XLEN]) begin
                        w_acc_d = w_div_trial[XLEN-1:0];
                        w_lo_d  = {r_lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        w_acc_d = w_div_shift[XLEN-1:0];
                        w_lo_d  = {r_lo_q[XLEN-2:0], 1'b0};
                    end
                    if (r_cnt_q == CNT_W'(1)) begin
                        w_state_d = MDU_DONE;
                    end
                end
                MDU_DONE: begin
                    o_done    = 1'b1;
                    w_state_d = MDU_IDLE;
                end
                default: begin
                    w_state_d = MDU_IDLE;
                end
            endcase
        end
    end

    // Pick the requested half of the accumulator pair
    always_comb begin
        o_result = '0;
        case (r_op_q)
            ALU_MUL:   o_result = r_lo_q;
            ALU_MULHU: o_result = r_acc_q;
            ALU_DIVU:  o_result = r_lo_q;
            ALU_REMU:  o_result = r_acc_q;
            default:   o_result = '0;
        endcase
    end

endmodule : mdu_iterative
`default_nettype wire

// File: rtl/execute_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage_mdu
// Brief    : Execute stage: operand mux, single-cycle ALU, zero flag, branch
//            target adder, iterative MDU with stall, flush and E/M register.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage_mdu
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RADD_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_E,
    input  logic              flush_E,
    input  logic [XLEN-1:0]   rd1_E,
    input  logic [XLEN-1:0]   rd2_E,
    input  logic [XLEN-1:0]   PC_E,
    input  logic [RADD_W-1:0] Radd_E,
    input  logic [XLEN-1:0]   extend_out_E,
    input  logic              ALU_src_E,
    input  logic [3:0]        ALU_control_E,
    output logic [XLEN-1:0]   next_PC_target_E,
    output logic              ZERO_E,
    output logic              stall_E,
    output logic              valid_M,
    output logic [XLEN-1:0]   ALU_result_M,
    output logic [XLEN-1:0]   Write_Data_M,
    output logic [RADD_W-1:0] Radd_M
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0]   w_src_b;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN-1:0]   w_alu_result;
    logic              w_is_mdu;
    logic              w_mdu_start;
    logic              w_mdu_busy;
    logic              w_mdu_done;
    logic [XLEN-1:0]   w_mdu_result;

    logic              r_valid_m_q, w_valid_m_d;
    logic [XLEN-1:0]   r_result_m_q, w_result_m_d;
    logic [XLEN-1:0]   r_wdata_m_q, w_wdata_m_d;
    logic [RADD_W-1:0] r_radd_m_q, w_radd_m_d;

    assign w_src_b          = ALU_src_E ? extend_out_E : rd2_E;
    assign w_shamt          = w_src_b[SHW-1:0];
    assign next_PC_target_E = PC_E + extend_out_E;
    assign w_is_mdu         = is_mdu(ALU_control_E);
    assign w_mdu_start      = valid_E & w_is_mdu & ~flush_E;
    assign ZERO_E           = ~w_is_mdu & (w_alu_result == '0);
    assign stall_E          = w_mdu_busy;

    // Single-cycle ALU; MDU and undefined codes produce zero here
    always_comb begin
        w_alu_result = '0;
        case (ALU_control_E)
            ALU_ADD:  w_alu_result = rd1_E + w_src_b;
            ALU_SUB:  w_alu_result = rd1_E - w_src_b;
            ALU_AND:  w_alu_result = rd1_E & w_src_b;
            ALU_OR:   w_alu_result = rd1_E | w_src_b;
            ALU_XOR:  w_alu_result = rd1_E ^ w_src_b;
            ALU_SLT:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(rd1_E) < $signed(w_src_b))};
            ALU_SLTU: w_alu_result = {{(XLEN-1){1'b0}}, (rd1_E < w_src_b)};
            ALU_SLL:  w_alu_result = rd1_E << w_shamt;
            ALU_SRL:  w_alu_result = rd1_E >> w_shamt;
            ALU_SRA:  w_alu_result = $unsigned($signed(rd1_E) >>> w_shamt);
            default:  w_alu_result = '0;
        endcase
    end

    mdu_iterative #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_mdu_start),
        .i_flush  (flush_E),
        .i_op     (ALU_control_E),
        .i_opa    (rd1_E),
        .i_opb    (w_src_b),
        .o_busy   (w_mdu_busy),
        .o_done   (w_mdu_done),
        .o_result (w_mdu_result)
    );

    // E/M next value: flush and stall insert a bubble and hold the payload
    always_comb begin
        w_valid_m_d  = 1'b0;
        w_result_m_d = r_result_m_q;
        w_wdata_m_d  = r_wdata_m_q;
        w_radd_m_d   = r_radd_m_q;
        if (!flush_E && !w_mdu_busy) begin
            w_valid_m_d = valid_E;
            if (valid_E) begin
                w_result_m_d = w_mdu_done ? w_mdu_result : w_alu_result;
                w_wdata_m_d  = rd2_E;
                w_radd_m_d   = Radd_E;
            end
        end
    end

    // E/M pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_m_q  <= 1'b0;
            r_result_m_q <= '0;
            r_wdata_m_q  <= '0;
            r_radd_m_q   <= '0;
        end else begin
            r_valid_m_q  <= w_valid_m_d;
            r_result_m_q <= w_result_m_d;
            r_wdata_m_q  <= w_wdata_m_d;
            r_radd_m_q   <= w_radd_m_d;
        end
    end

    assign valid_M      = r_valid_m_q;
    assign ALU_result_M = r_result_m_q;
    assign Write_Data_M = r_wdata_m_q;
    assign Radd_M       = r_radd_m_q;

endmodule : execute_stage_mdu
`default_nettype wire
